// File: rtl/ohc_modulo_alu_pipe_if.sv
// ---------------------------------------------------------------------------
// ohc_modulo_alu_pipe_if
// Bundle for one modulo-M channel of the one-hot-coded (OHC) arithmetic unit.
//
// Handshake semantics, used on both sides of the unit:
//   A transfer happens on a rising clock edge where valid & ready are both 1.
//   The producer keeps valid and its payload stable until that transfer.
//   ready never depends combinationally on valid.
//
// Signals
//   in_valid / in_ready : upstream handshake (in_ready driven by the unit)
//   op [1:0]            : 00 a+b, 01 a-b, 10 acc+a, 11 acc:=a
//   a, b [M-1:0]        : one-hot operands (b ignored for ops 10/11)
//   out_valid/out_ready : downstream handshake (out_ready driven downstream)
//   result [M-1:0]      : one-hot result, all zero when err is set
//   err                 : an operand that was checked was not exactly one-hot
//   acc_out [M-1:0]     : current accumulator register
//
// Modports
//   master : the side that supplies operands and consumes results
//   slave  : the arithmetic unit itself
// ---------------------------------------------------------------------------
interface ohc_modulo_alu_pipe_if #(
   parameter int M = 9
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [M-1:0] a;
   logic [M-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] result;
   logic         err;
   logic [M-1:0] acc_out;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, err, acc_out
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, err, acc_out
   );
endinterface

// File: rtl/ohc_modulo_alu_pipe.sv
// ---------------------------------------------------------------------------
// ohc_modulo_alu_pipe
// Pipelined one-hot-coded modulo-M arithmetic unit for one RNS channel.
// Supports add, subtract, accumulate and accumulator load, with one-hot
// legality checking and a two-register pipeline behind a valid/ready
// handshake.
//
// Parameters
//   M      : modulus and one-hot code width (M >= 2); bit i set = residue i
//   ACC_EN : 0 turns ops 10/11 into plain adds and pins acc_out at zero
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : ohc_modulo_alu_pipe_if slave modport (operands, results, acc)
//
// Pipeline
//   stage 1 : decoded operand pair (x, y) plus legality flag
//   stage 2 : registered result/err, drives out_valid
//   Occupancy is at most two items; one item per cycle in steady state.
//
// Accumulator
//   Written on the same edge that accepts an op 10/11, so a following
//   accumulate already sees the new value. The result emitted for op 10/11
//   is the value the accumulator took on that edge.
// ---------------------------------------------------------------------------
module ohc_modulo_alu_pipe #(
   parameter int M      = 9,
   parameter bit ACC_EN = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   ohc_modulo_alu_pipe_if.slave   bus
);

   typedef logic [M-1:0] ohc_t;

   localparam ohc_t ZERO_CODE = ohc_t'(1);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ACC  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   // ------------------------------------------------------------------
   // One-hot arithmetic helpers
   // ------------------------------------------------------------------

   // Modular sum of two one-hot codes: each set bit x[i] contributes y
   // rotated left by i, which places y[(k-i) mod M] at position k.
   function automatic ohc_t ohc_add(input ohc_t x, input ohc_t y);
      ohc_t r;
      r = '0;
      for (int i = 0; i < M; i++) begin
         if (((x >> i) & ohc_t'(1)) != '0) begin
            r = r | ohc_t'((y << i) | (y >> (M - i)));
         end
      end
      return r;
   endfunction

   // Modular negation: residue 0 stays put, residue j maps to M-j, which is
   // a bit reversal of positions 1..M-1.
   function automatic ohc_t ohc_neg(input ohc_t y);
      ohc_t r;
      r = y & ohc_t'(1);
      for (int j = 1; j < M; j++) begin
         if (((y >> (M - j)) & ohc_t'(1)) != '0) begin
            r = r | (ohc_t'(1) << j);
         end
      end
      return r;
   endfunction

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
   function automatic logic ohc_legal(input ohc_t x);
      return (x != '0) && ((x & (x - ohc_t'(1))) == '0);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic s1_valid;
   ohc_t s1_x;
   ohc_t s1_y;
   logic s1_err;

   logic out_valid_q;
   ohc_t result_q;
   logic err_q;

   ohc_t acc_q;

   // ------------------------------------------------------------------
   // Flow control
   // ------------------------------------------------------------------
   logic s2_load;
   logic s1_load;
   logic in_fire;

   // in_ready is a function of downstream readiness and pipeline occupancy
   // only; it is held low while reset is applied.
   assign s2_load  = !out_valid_q || bus.out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_fire  = bus.in_valid && bus.in_ready;

   // ------------------------------------------------------------------
   // Input decode
   // ------------------------------------------------------------------
   logic [1:0] eff_op;
   logic       a_ok;
   logic       b_ok;
   ohc_t       d_x;
   ohc_t       d_y;
   logic       d_err;
   ohc_t       acc_nxt;
   logic       acc_we;

   always_comb begin
      eff_op  = bus.op;
      d_x     = bus.a;
      d_y     = bus.b;
      d_err   = 1'b0;
      acc_nxt = acc_q;
      acc_we  = 1'b0;

      // Without an accumulator, ops 10/11 degrade to a plain add.
      if (!ACC_EN && bus.op[1]) begin
         eff_op = OP_ADD;
      end

      a_ok = ohc_legal(bus.a);
      b_ok = ohc_legal(bus.b);

      case (eff_op)
         OP_ADD: begin
            d_x   = bus.a;
            d_y   = bus.b;
            d_err = !(a_ok && b_ok);
         end
         OP_SUB: begin
            d_x   = bus.a;
            d_y   = ohc_neg(bus.b);
            d_err = !(a_ok && b_ok);
         end
         OP_ACC: begin
            d_x     = acc_q;
            d_y     = bus.a;
            d_err   = !a_ok;
            acc_nxt = ohc_add(acc_q, bus.a);
         end
         OP_LOAD: begin
            // Adding the zero code makes stage 2 reproduce a unchanged.
            d_x     = bus.a;
            d_y     = ZERO_CODE;
            d_err   = !a_ok;
            acc_nxt = bus.a;
         end
         default: begin
            d_x   = bus.a;
            d_y   = bus.b;
            d_err = 1'b1;
         end
      endcase

      // An illegal operand never disturbs the accumulator.
      acc_we = in_fire && eff_op[1] && !d_err;
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_x        <= '0;
         s1_y        <= '0;
         s1_err      <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         err_q       <= 1'b0;
         acc_q       <= ZERO_CODE;
      end else begin
         if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
               s1_x   <= d_x;
               s1_y   <= d_y;
               s1_err <= d_err;
            end
         end

         // Stage 2 only advances when its current content is consumed or
         // empty, which keeps result/err stable under backpressure.
         if (s2_load) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
               result_q <= s1_err ? '0 : ohc_add(s1_x, s1_y);
               err_q    <= s1_err;
            end
         end

         if (acc_we) begin
            acc_q <= acc_nxt;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.in_ready  = !rst && s1_load;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.err       = err_q;
   assign bus.acc_out   = acc_q;

endmodule
